dmux_fifo16: RTL and testbench

DMUX_FIFO16 -- requirements
Module: dmux_fifo16

---
 rtl/dmux_fifo16.sv | 97 +++++++++
 tb/tb_dmux_fifo16.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmux_fifo16.sv
// Two-lane demultiplexing FIFO: each accepted word goes to lane A (sel=0) or lane B (sel=1).
// Each lane is a DEPTH-entry circular buffer with a valid/ready pop interface and an occupancy count.
module dmux_fifo16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in,
  input  logic                     sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         a,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [WIDTH-1:0]         b,
  output logic                     b_valid,
  input  logic                     b_ready,
  output logic [$clog2(DEPTH):0]   a_count,
  output logic [$clog2(DEPTH):0]   b_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Lane index 0 is lane A, index 1 is lane B.
  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [PW-1:0]    wr_ptr [2];
  logic [PW-1:0]    rd_ptr [2];
  logic [CW-1:0]    count  [2];

  logic [1:0] nonempty;
  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] pop_req;

  assign pop_req = {b_ready, a_ready};

  always_comb begin
    nonempty = '0;
    full     = '0;
    push     = '0;
    pop      = '0;
    for (int i = 0; i < 2; i++) begin
      nonempty[i] = (count[i] != '0);
      full[i]     = (count[i] == FULL);
      pop[i]      = nonempty[i] & pop_req[i];
    end
    // in_ready only looks at the selected lane's occupancy, never at same-cycle pops.
    in_ready = sel ? ~full[1] : ~full[0];
    push[0]  = in_valid & in_ready & ~sel;
    push[1]  = in_valid & in_ready &  sel;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Storage is not reset; a reset simply abandons the contents via the pointers.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i] && !reset) mem[i][wr_ptr[i]] <= in;
    end
  end

  always_comb begin
    a = '0;
    b = '0;
    if (nonempty[0]) a = mem[0][rd_ptr[0]];
    if (nonempty[1]) b = mem[1][rd_ptr[1]];
  end

  assign a_valid = nonempty[0];
  assign b_valid = nonempty[1];
  assign a_count = count[0];
  assign b_count = count[1];

endmodule

// File: tb/tb_dmux_fifo16.sv
// Randomised and directed bench for dmux_fifo16 against a queue-based model of the two lanes.
module tb_dmux_fifo16;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic             sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b;
  logic             b_valid;
  logic             b_ready;
  logic [2:0]       a_count;
  logic [2:0]       b_count;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  bit               model_ok = 1'b0;

  always #5 clock = ~clock;

  dmux_fifo16 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .in       (in),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b        (b),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    int               sel_size;
    ea = (qa.size() != 0) ? qa[0] : '0;
    eb = (qb.size() != 0) ? qb[0] : '0;
    sel_size = sel ? qb.size() : qa.size();
    chk("a",        32'(a),        32'(ea));
    chk("a_valid",  32'(a_valid),  32'(qa.size() != 0));
    chk("a_count",  32'(a_count),  32'(qa.size()));
    chk("b",        32'(b),        32'(eb));
    chk("b_valid",  32'(b_valid),  32'(qb.size() != 0));
    chk("b_count",  32'(b_count),  32'(qb.size()));
    chk("in_ready", 32'(in_ready), 32'(sel_size < DEPTH));
  endtask

  // Drive one cycle of inputs, compare against the model, then advance the model at the edge.
  task automatic cycle(input logic r, input logic iv, input logic s,
                       input logic [WIDTH-1:0] d, input logic ar, input logic br);
    bit pa;
    bit pb;
    bit pu;
    @(negedge clock);
    reset    = r;
    in_valid = iv;
    sel      = s;
    in       = d;
    a_ready  = ar;
    b_ready  = br;
    #1;
    if (model_ok) check_outputs();
    @(posedge clock);
    if (r) begin
      qa.delete();
      qb.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      pa = ar && (qa.size() > 0);
      pb = br && (qb.size() > 0);
      pu = iv && ((s ? qb.size() : qa.size()) < DEPTH);
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      if (pu) begin
        if (s) qb.push_back(d);
        else   qa.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; in = '0; sel = 1'b0; in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // Post-reset state
    chk("rst_a", 32'(a), 0);
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_b_valid", 32'(b_valid), 0);
    chk("rst_counts", 32'({a_count, b_count}), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // Basic routing
    cycle(0, 1, 0, 16'h1234, 0, 0);
    cycle(0, 1, 1, 16'hABCD, 0, 0);
    chk("route_a", 32'(a), 32'h1234);
    chk("route_a_valid", 32'(a_valid), 1);
    chk("route_b", 32'(b), 32'hABCD);
    chk("route_b_valid", 32'(b_valid), 1);
    chk("route_a_count", 32'(a_count), 1);
    chk("route_b_count", 32'(b_count), 1);

    // Full backpressure on lane A
    cycle(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 16'h0100 + 16'(k), 0, 0);
    chk("full_a_count", 32'(a_count), 4);
    chk("full_in_ready_a", 32'(in_ready), 0);
    cycle(0, 1, 0, 16'hDEAD, 0, 0);
    chk("full_fifth_ignored", 32'(a_count), 4);
    chk("full_head_kept", 32'(a), 32'h0100);
    sel = 1'b1;
    #1;
    chk("full_in_ready_b", 32'(in_ready), 1);

    // Order and pointer wrap with a pop every cycle after the first push
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 16'h0001, 0, 0);
    for (int k = 2; k <= 6; k++) begin
      cycle(0, 1, 0, 16'(k), 1, 0);
      chk("wrap_head", 32'(a), 32'(k));
      chk("wrap_count_le2", 32'(a_count <= 2), 1);
    end
    cycle(0, 0, 0, 0, 1, 0);
    chk("wrap_drained", 32'(a_count), 0);

    // Simultaneous push and pop
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 16'h0011, 0, 0);
    cycle(0, 1, 0, 16'h0022, 0, 0);
    cycle(0, 1, 0, 16'h0033, 1, 0);
    chk("same_lane_count", 32'(a_count), 2);
    chk("same_lane_head", 32'(a), 32'h0022);
    cycle(0, 1, 1, 16'h0044, 1, 0);
    chk("cross_a_count", 32'(a_count), 1);
    chk("cross_b_count", 32'(b_count), 1);
    chk("cross_a_tail", 32'(a), 32'h0033);
    chk("cross_b_head", 32'(b), 32'h0044);

    // Reset mid-operation with a push and a pop presented
    cycle(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 16'h0A00 + 16'(k), 0, 0);
      cycle(0, 1, 1, 16'h0B00 + 16'(k), 0, 0);
    end
    chk("pre_rst_counts", 32'({a_count, b_count}), 32'({3'd3, 3'd3}));
    cycle(1, 1, 0, 16'h5555, 1, 1);
    chk("midrst_counts", 32'({a_count, b_count}), 0);
    chk("midrst_ab", 32'({a, b}), 0);
    chk("midrst_valids", 32'({a_valid, b_valid}), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);

    // Pop on an empty lane
    cycle(0, 0, 0, 0, 1, 0);
    chk("empty_pop_count", 32'(a_count), 0);
    chk("empty_pop_a", 32'(a), 0);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom % 97) == 0, ($urandom % 4) != 0, 1'($urandom),
            16'($urandom), ($urandom % 3) == 0, ($urandom % 2) == 0);
    end
    cycle(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
